// File: rtl/ahb_gpio_pkg.sv
// ahb_gpio_pkg
//   Shared constants and types for the AHB-Lite GPIO slave: data width,
//   register offsets, AHB transfer-type encodings and the pin direction enum.
`timescale 1ns/1ps
package ahb_gpio_pkg;

    localparam int DATA_W = 16;

    localparam logic [7:0] ADDR_DATA = 8'h00;
    localparam logic [7:0] ADDR_DIR  = 8'h04;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        DIR_IN  = 1'b0,
        DIR_OUT = 1'b1
    } dir_e;

endpackage

// File: rtl/ahb_gpio_if.sv
// ahb_gpio_if
//   AHB-Lite bus signals seen by the GPIO slave.
//   master modport: drives HSEL/HADDR/HTRANS/HWRITE/HREADY/HWDATA,
//                   receives HREADYOUT/HRDATA.
//   slave modport : the mirror image.
`timescale 1ns/1ps
interface ahb_gpio_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA,
        input  HREADYOUT, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA,
        output HREADYOUT, HRDATA
    );

endinterface

// File: rtl/gpio_parity.sv
// gpio_parity
//   Parity bit for a data word.
//   data    : word to cover
//   odd_sel : 1 = odd parity (bit makes total ones odd), 0 = even parity
//   parity  : generated parity bit
// Used both to generate the output parity bit and, XORed with a received
// parity bit, to detect an input parity error.
`timescale 1ns/1ps
module gpio_parity #(
    parameter int W = 16
) (
    input  logic [W-1:0] data,
    input  logic         odd_sel,
    output logic         parity
);

    assign parity = odd_sel ? ~^data : ^data;

endmodule

// File: rtl/ahb_gpio.sv
// ahb_gpio
//   AHB-Lite slave GPIO port: DATA_W data pins plus one parity pin (MSB).
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   bus           : AHB-Lite slave interface (zero wait states, never errors)
//   GPIOIN        : input pins  {parity, data}
//   GPIOOUT       : output pins {parity, data}
//   PARITYERR     : registered parity error of the sampled input pins
//   PARITYSEL     : 1 = odd parity, 0 = even parity (applies every cycle)
// Register map: 0x00 data, 0x04 direction (bit 0: 1 = output, 0 = input).
`timescale 1ns/1ps
module ahb_gpio #(
    parameter int DATA_W = ahb_gpio_pkg::DATA_W
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    ahb_gpio_if.slave       bus,
    input  logic [DATA_W:0] GPIOIN,
    output logic [DATA_W:0] GPIOOUT,
    output logic            PARITYERR,
    input  logic            PARITYSEL
);

    import ahb_gpio_pkg::*;

    // Address-phase pipeline
    logic        valid_q;
    logic        write_q;
    logic [7:0]  addr_q;

    // Programmer-visible state
    dir_e              dir_q;
    logic [DATA_W:0]   gpio_out_q;
    logic [DATA_W-1:0] gpio_datain_q;
    logic              parity_err_q;

    logic        out_parity;
    logic        in_parity;
    logic        wr_en;
    logic [31:0] rdata;

    // Upper address bits, HTRANS[0] and upper write-data bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{bus.HADDR[31:8], bus.HTRANS[0], bus.HWDATA[31:DATA_W]};

    gpio_parity #(.W(DATA_W)) u_out_parity (
        .data    (bus.HWDATA[DATA_W-1:0]),
        .odd_sel (PARITYSEL),
        .parity  (out_parity)
    );

    // Expected parity of the incoming data; it differs from the received
    // parity bit exactly when the 17-bit word violates the selected sense.
    gpio_parity #(.W(DATA_W)) u_in_parity (
        .data    (GPIOIN[DATA_W-1:0]),
        .odd_sel (PARITYSEL),
        .parity  (in_parity)
    );

    // NOTE: registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
        end else if (bus.HSEL && bus.HREADY && bus.HTRANS[1]) begin
            valid_q <= 1'b1;
            write_q <= bus.HWRITE;
            addr_q  <= bus.HADDR[7:0];
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign wr_en = valid_q && write_q;

    // Data phase and input sampler. The data write checks the direction
    // currently held in dir_q, so a dir write immediately followed by a data
    // write sees the new direction.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dir_q         <= DIR_IN;
            gpio_out_q    <= '0;
            gpio_datain_q <= '0;
            parity_err_q  <= 1'b0;
        end else begin
            if (wr_en && addr_q == ADDR_DIR)
                dir_q <= dir_e'(bus.HWDATA[0]);
            if (wr_en && addr_q == ADDR_DATA && dir_q == DIR_OUT)
                gpio_out_q <= {out_parity, bus.HWDATA[DATA_W-1:0]};
            // In output mode the sampler freezes and the error flag holds.
            if (dir_q == DIR_IN) begin
                gpio_datain_q <= GPIOIN[DATA_W-1:0];
                parity_err_q  <= in_parity ^ GPIOIN[DATA_W];
            end
        end
    end

    // Read data is a pure decode of registered state, valid in the data phase.
    always_comb begin
        // NOTE: default assignment first keeps this block free of latches.
        rdata = '0;
        if (valid_q && !write_q) begin
            case (addr_q)
                ADDR_DATA: rdata[DATA_W-1:0] = (dir_q == DIR_OUT) ? gpio_out_q[DATA_W-1:0]
                                                                  : gpio_datain_q;
                ADDR_DIR:  rdata[0] = (dir_q == DIR_OUT);
                default:   rdata = '0;
            endcase
        end
    end

    assign bus.HRDATA    = rdata;
    assign bus.HREADYOUT = 1'b1;
    assign GPIOOUT       = gpio_out_q;
    assign PARITYERR     = parity_err_q;

endmodule

// File: tb/tb_ahb_gpio.sv
// tb_ahb_gpio
//   Directed self-checking bench for ahb_gpio: reset values, output parity
//   generation, input parity checking, direction gating, ignored transfers,
//   pipelined transfers, reset mid-transfer, and a randomised loopback.
`timescale 1ns/1ps
module tb_ahb_gpio;

    import ahb_gpio_pkg::*;

    logic        HCLK;
    logic        HRESETn;
    logic [16:0] GPIOIN;
    logic [16:0] GPIOOUT;
    logic        PARITYERR;
    logic        PARITYSEL;

    ahb_gpio_if bus ();

    ahb_gpio dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .bus       (bus),
        .GPIOIN    (GPIOIN),
        .GPIOOUT   (GPIOOUT),
        .PARITYERR (PARITYERR),
        .PARITYSEL (PARITYSEL)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // One transfer: address phase, then data phase; rdata is HRDATA in the data phase.
    task automatic ahb_xfer(input logic hsel, input logic [1:0] htrans, input logic hready,
                            input logic hwrite, input logic [7:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata);
        @(negedge HCLK);
        bus.HSEL   = hsel;
        bus.HTRANS = htrans;
        bus.HREADY = hready;
        bus.HWRITE = hwrite;
        bus.HADDR  = {24'h0, addr};
        @(negedge HCLK);
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        bus.HREADY = 1'b1;
        bus.HWDATA = wdata;
        rdata      = bus.HRDATA;
        @(negedge HCLK);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        ahb_xfer(1'b1, HTRANS_NONSEQ, 1'b1, 1'b1, addr, data, dummy);
    endtask

    task automatic rd(input logic [7:0] addr, output logic [31:0] data);
        ahb_xfer(1'b1, HTRANS_NONSEQ, 1'b1, 1'b0, addr, 32'h0, data);
    endtask

    // Two back-to-back writes with overlapping address/data phases.
    task automatic wr2(input logic [7:0] a1, input logic [31:0] d1,
                       input logic [7:0] a2, input logic [31:0] d2);
        @(negedge HCLK);
        bus.HSEL = 1'b1; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b1; bus.HADDR = {24'h0, a1};
        @(negedge HCLK);
        bus.HWDATA = d1; bus.HTRANS = HTRANS_SEQ; bus.HADDR = {24'h0, a2};
        @(negedge HCLK);
        bus.HWDATA = d2; bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE;
        @(negedge HCLK);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = HTRANS_IDLE;
        bus.HWRITE = 1'b0; bus.HREADY = 1'b1; bus.HWDATA = '0;
        GPIOIN = '0; PARITYSEL = 1'b0;

        // Reset
        HRESETn = 1'b0;
        #50;
        check("rst_gpioout", GPIOOUT, 32'h0);
        check("rst_perr", PARITYERR, 32'h0);
        check("rst_hreadyout", bus.HREADYOUT, 32'h1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        rd(ADDR_DIR, r);
        check("rst_rd_dir", r, 32'h0);
        check("hreadyout_run", bus.HREADYOUT, 32'h1);

        // Output mode and parity generation
        wr(ADDR_DIR, 32'h1);
        rd(ADDR_DIR, r);
        check("rd_dir_out", r, 32'h1);
        PARITYSEL = 1'b0; wr(ADDR_DATA, 32'h0003);
        check("out_3_even", GPIOOUT, 32'h00003);
        PARITYSEL = 1'b1; wr(ADDR_DATA, 32'h0003);
        check("out_3_odd", GPIOOUT, 32'h10003);
        PARITYSEL = 1'b0; wr(ADDR_DATA, 32'h0001);
        check("out_1_even", GPIOOUT, 32'h10001);
        rd(ADDR_DATA, r);
        check("rd_data_out", r, 32'h1);

        // Sampler frozen in output mode: a bad word must not raise the flag
        GPIOIN = 17'h10003;
        repeat (3) @(negedge HCLK);
        check("perr_frozen", PARITYERR, 32'h0);
        GPIOIN = 17'h0;

        // Pipelined: dir=0 then data write -> data write sees input mode
        wr2(ADDR_DIR, 32'h0, ADDR_DATA, 32'h1234);
        check("b2b_dir_in", GPIOOUT, 32'h10001);
        // Pipelined: dir=1 then data write -> data write sees output mode
        wr2(ADDR_DIR, 32'h1, ADDR_DATA, 32'h00F0);
        check("b2b_dir_out", GPIOOUT, 32'h000F0);

        // Input mode and parity checking
        wr(ADDR_DIR, 32'h0);
        PARITYSEL = 1'b0;
        GPIOIN = 17'h00003;
        @(negedge HCLK);
        check("perr_even_ok", PARITYERR, 32'h0);
        GPIOIN = 17'h10003;
        @(negedge HCLK);
        check("perr_even_bad", PARITYERR, 32'h1);
        PARITYSEL = 1'b1;
        @(negedge HCLK);
        check("perr_odd_ok", PARITYERR, 32'h0);
        PARITYSEL = 1'b0;
        rd(ADDR_DATA, r);
        check("rd_data_in", r, 32'h3);

        // Ignored writes
        wr(ADDR_DATA, 32'hFFFF);
        check("wr_in_mode", GPIOOUT, 32'h000F0);
        ahb_xfer(1'b0, HTRANS_NONSEQ, 1'b1, 1'b1, ADDR_DIR, 32'h1, r);
        rd(ADDR_DIR, r);
        check("hsel0_ignored", r, 32'h0);
        ahb_xfer(1'b1, HTRANS_IDLE, 1'b1, 1'b1, ADDR_DIR, 32'h1, r);
        ahb_xfer(1'b1, HTRANS_BUSY, 1'b1, 1'b1, ADDR_DIR, 32'h1, r);
        rd(ADDR_DIR, r);
        check("idle_busy_ignored", r, 32'h0);
        ahb_xfer(1'b1, HTRANS_NONSEQ, 1'b0, 1'b1, ADDR_DIR, 32'h1, r);
        rd(ADDR_DIR, r);
        check("hready0_ignored", r, 32'h0);
        wr(8'h08, 32'h1);
        rd(8'h08, r);
        check("rd_unmapped", r, 32'h0);
        rd(ADDR_DIR, r);
        check("unmapped_no_side", r, 32'h0);

        // Reset during a data phase aborts the write
        wr(ADDR_DIR, 32'h1);
        @(negedge HCLK);
        bus.HSEL = 1'b1; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b1; bus.HADDR = 32'h0;
        @(negedge HCLK);
        bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE; bus.HWDATA = 32'hABCD;
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        check("rst_mid_gpioout", GPIOOUT, 32'h0);
        rd(ADDR_DIR, r);
        check("rst_mid_dir", r, 32'h0);

        // Loopback: drive out, feed back (optionally corrupted), check in
        for (int i = 0; i < 100; i++) begin
            logic [15:0] d;
            logic        psel;
            logic        inj;
            logic [16:0] exp_out;
            logic [16:0] pins;
            int          bit_idx;
            d    = 16'($urandom);
            psel = 1'($urandom_range(0, 1));
            inj  = 1'($urandom_range(0, 1));
            PARITYSEL = psel;
            wr(ADDR_DIR, 32'h1);
            wr(ADDR_DATA, {16'h0, d});
            exp_out = {(psel ? ~^d : ^d), d};
            check("lb_out", GPIOOUT, {15'h0, exp_out});
            pins = exp_out;
            if (inj) begin
                bit_idx = $urandom_range(0, 16);
                pins[bit_idx] = ~pins[bit_idx];
            end
            GPIOIN = pins;
            wr(ADDR_DIR, 32'h0);
            @(negedge HCLK);
            check("lb_perr", PARITYERR, {31'h0, inj});
            rd(ADDR_DATA, r);
            check("lb_rd", r, {16'h0, pins[15:0]});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
